instr_fetch_initiator: RTL and testbench
========================================

Name: instr_fetch_initiator

Overview:
- OBI-style instruction fetch initiator for the cheriot testbench; the requester end of the instruction-side req/gnt/rvalid interface.
- Issues sequential word fetches toward the instruction memory model and tolerates randomized grant/response latency.
- Buffers returned words with their addresses into a small response FIFO drained by a ready/valid consumer.
- Supports PC redirect with discard of in-flight responses and flags protocol violations by the responder.

Parameters:
DEPTH, 4, max outstanding requests plus buffered responses (power of 2, 2..16)
RESET_ADDR, 32'h8000_0000, first fetch address after reset (word aligned)

Ports:
clk  input  1  clock, all state on posedge
rst  input  1  asynchronous active-high reset
fetch_en  input  1  permit new requests to be issued
redirect_valid  input  1  one-cycle pulse: restart fetch at redirect_addr
redirect_addr  input  32  new fetch address; bits[1:0] ignored (forced 0)
instr_req  output  1  OBI request
instr_addr  output  32  OBI request address, word aligned
instr_gnt  input  1  OBI grant
instr_rvalid  input  1  OBI response valid
instr_rdata  input  32  OBI response data
instr_err  input  1  OBI response error
out_valid  output  1  FIFO head valid
out_ready  input  1  consumer accepts head
out_addr  output  32  fetch address of head word
out_rdata  output  32  head data
out_err  output  1  head error flag
outstanding  output  5  granted requests awaiting rvalid (incl. discarded)
proto_err  output  1  sticky: responder protocol violation

Behaviour:
- Reset (async, rst=1): instr_req=0, instr_addr=RESET_ADDR, next-fetch PC=RESET_ADDR, out_valid=0, FIFO empty, outstanding=0, discard count=0, proto_err=0, state IDLE.
- All outputs registered, except out_* (driven from FIFO head storage).
- Credit: a new request may start only if outstanding + fifo_count + (1 if request currently pending) < DEPTH. This guarantees FIFO space for every response, so rvalid is never backpressured.
- FSM IDLE: instr_req=0. If fetch_en and credit are available, go to REQ next cycle with instr_req=1 and instr_addr=PC.
- FSM REQ: instr_req and instr_addr are held stable until instr_gnt (OBI rule; never drop req or change addr before gnt).
  - On req&gnt: outstanding+1; the address is pushed to the in-flight address queue; PC=PC+4 (mod 2^32, 32'hFFFF_FFFC wraps to 0).
  - Same-cycle decision: if fetch_en and credit remain after this grant, stay in REQ with the new address (back-to-back); else go to IDLE.
- Response handling:
  - On instr_rvalid with outstanding>0: outstanding-1 and the oldest address is popped.
  - If discard count>0: decrement it and drop the response.
  - Else: push {addr, rdata, err} into the FIFO; out_valid rises the next cycle.
  - rvalid in the same cycle as a grant: outstanding unchanged; the grant's address is queued behind the popped one.
  - instr_rvalid with outstanding==0 (gnt not counted that cycle): proto_err<=1 (sticky until reset); response ignored.
- FIFO: pop on out_valid&out_ready. Simultaneous push and pop is allowed at full and empty. When empty, out_* hold the last values and out_valid=0.
- Redirect (redirect_valid=1):
  - FIFO flushed: out_valid=0 next cycle, and a same-cycle pop is ignored.
  - discard count = outstanding after this cycle's grant/rvalid updates. A grant in the same cycle counts as outstanding and is discarded; an rvalid in the same cycle is dropped.
  - PC = {redirect_addr[31:2], 2'b00}.
  - If a request is pending without gnt: it stays asserted with its old address, is discarded on response, and the next request uses the redirect PC.
  - If no request is pending: the next request uses the redirect PC.
- fetch_en=0 never withdraws a pending request; it only blocks new ones.
- instr_err responses are passed through with out_err=1 and fetching continues; error handling is the consumer's job.

Test Plan:
- Reset, fetch_en=1, GNT/RESP wait 0, out_ready=1 -> instr_addr sequence 80000000, 80000004, 80000008...; out_addr/out_rdata match memory words in order; outstanding never exceeds 4.
- out_ready=0, fetch_en=1 -> exactly 4 grants issued, then instr_req=0; FIFO full with 4 words; raising out_ready resumes at 80000010.
- Redirect to 32'h8000_0103 while 2 outstanding plus 1 pending ungranted (random waits) -> addr held until gnt; 3 responses dropped; first out_addr=80000100.
- PC 32'hFFFF_FFF8, fetch 3 words -> addresses FFFFFFF8, FFFFFFFC, 00000000.
- Responder error at 80000008 -> out_err=1 on that word only; neighbours have out_err=0; fetching continues.
- Force instr_rvalid with outstanding=0 -> proto_err=1 and stays 1; rst pulse mid-traffic -> all outputs return to reset values asynchronously.

Source files
------------

// File: rtl/instr_fetch_initiator.sv
// OBI instruction-side requester: sequential word fetch with PC redirect and a {addr,data,err} response FIFO.
// req/addr registered and held until gnt; credit limit guarantees FIFO room so rvalid is never stalled.
module instr_fetch_initiator #(
  parameter int unsigned DEPTH      = 4,
  parameter logic [31:0] RESET_ADDR = 32'h8000_0000
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        fetch_en,
  input  logic        redirect_valid,
  input  logic [31:0] redirect_addr,
  output logic        instr_req,
  output logic [31:0] instr_addr,
  input  logic        instr_gnt,
  input  logic        instr_rvalid,
  input  logic [31:0] instr_rdata,
  input  logic        instr_err,
  output logic        out_valid,
  input  logic        out_ready,
  output logic [31:0] out_addr,
  output logic [31:0] out_rdata,
  output logic        out_err,
  output logic [4:0]  outstanding,
  output logic        proto_err
);

  localparam int unsigned AW       = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam logic [5:0]  LP_DEPTH = 6'(DEPTH);

  typedef enum logic {S_IDLE, S_REQ} state_t;

  state_t        r_state;
  logic          r_req;
  logic [31:0]   r_addr;
  logic [31:0]   r_pc;
  logic [4:0]    r_outstanding;
  logic [4:0]    r_discard;
  logic          r_stale;
  logic          r_proto_err;

  logic [AW-1:0] r_aq_wr;
  logic [AW-1:0] r_aq_rd;
  logic [31:0]   r_aq_mem [DEPTH];

  logic [AW-1:0] r_fq_wr;
  logic [AW-1:0] r_fq_rd;
  logic [4:0]    r_fq_cnt;
  logic [31:0]   r_fq_addr [DEPTH];
  logic [31:0]   r_fq_data [DEPTH];
  logic          r_fq_err  [DEPTH];

  logic [31:0]   r_hold_addr;
  logic [31:0]   r_hold_data;
  logic          r_hold_err;

  logic          w_gnt_fire;
  logic          w_rsp_fire;
  logic          w_push;
  logic          w_pop;
  logic          w_issue;
  logic [5:0]    w_used;
  logic [31:0]   w_redir_pc;
  logic [31:0]   w_base_pc;
  logic [4:0]    w_out_nxt;
  logic          w_fq_nonempty;
  logic          w_unused_addr_lsb;

  assign w_unused_addr_lsb = ^redirect_addr[1:0];

  assign w_gnt_fire    = (r_state == S_REQ) && instr_gnt;
  assign w_rsp_fire    = instr_rvalid && (r_outstanding != 5'd0);
  assign w_push        = w_rsp_fire && (r_discard == 5'd0) && !redirect_valid;
  assign w_fq_nonempty = (r_fq_cnt != 5'd0);
  assign w_pop         = w_fq_nonempty && out_ready && !redirect_valid;
  assign w_used        = {1'b0, r_outstanding} + {1'b0, r_fq_cnt};
  assign w_redir_pc    = {redirect_addr[31:2], 2'b00};
  assign w_base_pc     = redirect_valid ? w_redir_pc : r_pc;
  assign w_out_nxt     = r_outstanding + {4'b0, w_gnt_fire} - {4'b0, w_rsp_fire};

  // In REQ the pending request still holds a credit until it is granted.
  assign w_issue = fetch_en &&
                   ((r_state == S_IDLE) ? (w_used < LP_DEPTH)
                                        : (w_gnt_fire && ((w_used + 6'd1) < LP_DEPTH)));

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state <= S_IDLE;
      r_req   <= 1'b0;
      r_addr  <= RESET_ADDR;
      r_pc    <= RESET_ADDR;
    end else begin
      if (w_issue) begin
        r_state <= S_REQ;
        r_req   <= 1'b1;
        r_addr  <= w_base_pc;
        r_pc    <= w_base_pc + 32'd4;
      end else begin
        r_pc <= w_base_pc;
        if (w_gnt_fire) begin
          r_state <= S_IDLE;
          r_req   <= 1'b0;
        end
      end
    end
  end

  // A request left pending across a redirect is marked stale and discarded once granted.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_outstanding <= 5'd0;
      r_discard     <= 5'd0;
      r_stale       <= 1'b0;
      r_proto_err   <= 1'b0;
    end else begin
      r_outstanding <= w_out_nxt;
      if (redirect_valid) begin
        r_discard <= w_out_nxt;
        r_stale   <= (r_state == S_REQ) && !instr_gnt;
      end else begin
        r_discard <= r_discard
                   - {4'b0, (w_rsp_fire && (r_discard != 5'd0))}
                   + {4'b0, (w_gnt_fire && r_stale)};
        if (w_gnt_fire) begin
          r_stale <= 1'b0;
        end
      end
      if (instr_rvalid && (r_outstanding == 5'd0)) begin
        r_proto_err <= 1'b1;
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_aq_wr <= '0;
      r_aq_rd <= '0;
    end else begin
      if (w_gnt_fire) r_aq_wr <= r_aq_wr + AW'(1);
      if (w_rsp_fire) r_aq_rd <= r_aq_rd + AW'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (w_gnt_fire) r_aq_mem[r_aq_wr] <= r_addr;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_fq_wr     <= '0;
      r_fq_rd     <= '0;
      r_fq_cnt    <= 5'd0;
      r_hold_addr <= 32'd0;
      r_hold_data <= 32'd0;
      r_hold_err  <= 1'b0;
    end else begin
      if (redirect_valid) begin
        r_fq_rd  <= r_fq_wr;
        r_fq_cnt <= 5'd0;
      end else begin
        if (w_push) r_fq_wr <= r_fq_wr + AW'(1);
        if (w_pop)  r_fq_rd <= r_fq_rd + AW'(1);
        r_fq_cnt <= r_fq_cnt + {4'b0, w_push} - {4'b0, w_pop};
      end
      if (w_fq_nonempty) begin
        r_hold_addr <= r_fq_addr[r_fq_rd];
        r_hold_data <= r_fq_data[r_fq_rd];
        r_hold_err  <= r_fq_err[r_fq_rd];
      end
    end
  end

  always_ff @(posedge clk) begin
    if (w_push) begin
      r_fq_addr[r_fq_wr] <= r_aq_mem[r_aq_rd];
      r_fq_data[r_fq_wr] <= instr_rdata;
      r_fq_err[r_fq_wr]  <= instr_err;
    end
  end

  assign instr_req   = r_req;
  assign instr_addr  = r_addr;
  assign outstanding = r_outstanding;
  assign proto_err   = r_proto_err;

  // Once drained, the head view freezes on the last word shown.
  assign out_valid = w_fq_nonempty;
  assign out_addr  = w_fq_nonempty ? r_fq_addr[r_fq_rd] : r_hold_addr;
  assign out_rdata = w_fq_nonempty ? r_fq_data[r_fq_rd] : r_hold_data;
  assign out_err   = w_fq_nonempty ? r_fq_err[r_fq_rd]  : r_hold_err;

endmodule

// File: tb/tb_instr_fetch_initiator.sv
// Directed bench for instr_fetch_initiator: OBI responder model with adjustable waits plus an output scoreboard.
module tb_instr_fetch_initiator;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        fetch_en = 1'b0;
  logic        redirect_valid = 1'b0;
  logic [31:0] redirect_addr = 32'd0;
  logic        instr_req;
  logic [31:0] instr_addr;
  logic        instr_gnt = 1'b0;
  logic        instr_rvalid = 1'b0;
  logic [31:0] instr_rdata = 32'd0;
  logic        instr_err = 1'b0;
  logic        out_valid;
  logic        out_ready = 1'b0;
  logic [31:0] out_addr;
  logic [31:0] out_rdata;
  logic        out_err;
  logic [4:0]  outstanding;
  logic        proto_err;

  instr_fetch_initiator #(.DEPTH(4), .RESET_ADDR(32'h8000_0000)) dut (
    .clk(clk), .rst(rst), .fetch_en(fetch_en),
    .redirect_valid(redirect_valid), .redirect_addr(redirect_addr),
    .instr_req(instr_req), .instr_addr(instr_addr), .instr_gnt(instr_gnt),
    .instr_rvalid(instr_rvalid), .instr_rdata(instr_rdata), .instr_err(instr_err),
    .out_valid(out_valid), .out_ready(out_ready), .out_addr(out_addr),
    .out_rdata(out_rdata), .out_err(out_err),
    .outstanding(outstanding), .proto_err(proto_err)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [31:0] addr;
    int          due;
  } rsp_t;

  rsp_t        rq[$];
  logic [31:0] gnt_log[$];
  logic [31:0] got_addr[$];
  logic [31:0] got_data[$];
  logic        got_err[$];

  int          n_checks;
  int          n_fail;
  int          gnt_limit = 32'h4000_0000;
  int          gnt_wait = 0;
  int          resp_wait = 0;
  bit          rand_mode = 1'b0;
  logic [31:0] err_addr = 32'h1;
  int          force_cnt = 0;
  int          force_seen = 0;
  int          cyc = 0;
  int          gw_left = -1;
  int          max_out = 0;
  int          stab_viol = 0;
  logic        prev_req = 1'b0;
  logic        prev_gnt = 1'b0;
  logic [31:0] prev_addr = 32'd0;

  function automatic logic [31:0] mem_word(input logic [31:0] a);
    return {a[15:0], a[31:16]} ^ 32'h1357_9BDF;
  endfunction

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  // Responder, output scoreboard and protocol monitors all evaluate on the falling edge.
  always @(negedge clk) begin
    rsp_t r;
    cyc++;
    if (rst) begin
      rq.delete();
      gw_left      = -1;
      instr_gnt    = 1'b0;
      instr_rvalid = 1'b0;
      instr_err    = 1'b0;
      instr_rdata  = 32'd0;
      prev_req     = 1'b0;
      prev_gnt     = 1'b0;
    end else begin
      if (prev_req && !prev_gnt && (!instr_req || instr_addr != prev_addr)) stab_viol++;
      if (out_valid && out_ready) begin
        got_addr.push_back(out_addr);
        got_data.push_back(out_rdata);
        got_err.push_back(out_err);
      end
      if (int'(outstanding) > max_out) max_out = int'(outstanding);
      instr_rvalid = 1'b0;
      instr_err    = 1'b0;
      instr_rdata  = 32'd0;
      if (force_cnt != force_seen) begin
        force_seen   = force_cnt;
        instr_rvalid = 1'b1;
        instr_rdata  = 32'hDEAD_BEEF;
      end else if (rq.size() > 0 && rq[0].due <= cyc) begin
        r            = rq.pop_front();
        instr_rvalid = 1'b1;
        instr_rdata  = mem_word(r.addr);
        instr_err    = (r.addr == err_addr);
      end
      instr_gnt = 1'b0;
      if (instr_req && gnt_log.size() < gnt_limit) begin
        if (gw_left < 0) gw_left = rand_mode ? int'($urandom_range(0, 3)) : gnt_wait;
        if (gw_left == 0) begin
          instr_gnt = 1'b1;
          r.addr = instr_addr;
          r.due  = cyc + 1 + (rand_mode ? int'($urandom_range(0, 3)) : resp_wait);
          rq.push_back(r);
          gnt_log.push_back(instr_addr);
          gw_left = -1;
        end else begin
          gw_left--;
        end
      end
      prev_req  = instr_req;
      prev_gnt  = instr_gnt;
      prev_addr = instr_addr;
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic pulse_redirect(input logic [31:0] a);
    redirect_valid = 1'b1;
    redirect_addr  = a;
    tick();
    redirect_valid = 1'b0;
  endtask

  task automatic wait_idle(input string tag);
    int k;
    k = 0;
    while (!(outstanding == 5'd0 && !instr_req && !out_valid) && k < 400) begin
      tick();
      k++;
    end
    check_eq({tag, "_idle"}, {31'd0, (k < 400)}, 32'd1);
  endtask

  task automatic wait_got(input int target, input string tag);
    int k;
    k = 0;
    while (got_addr.size() < target && k < 400) begin
      tick();
      k++;
    end
    check_eq({tag, "_got"}, {31'd0, (k < 400)}, 32'd1);
  endtask

  task automatic check_reset_outputs(input string tag);
    check_eq({tag, "_req"},   {31'd0, instr_req}, 32'd0);
    check_eq({tag, "_addr"},  instr_addr, 32'h8000_0000);
    check_eq({tag, "_oval"},  {31'd0, out_valid}, 32'd0);
    check_eq({tag, "_outst"}, {27'd0, outstanding}, 32'd0);
    check_eq({tag, "_proto"}, {31'd0, proto_err}, 32'd0);
  endtask

  initial begin
    int gb;
    int wb;
    int k;
    n_checks = 0;
    n_fail   = 0;

    #12;
    check_reset_outputs("rst0");
    tick();
    rst = 1'b0;

    // Zero-wait streaming from the reset address.
    out_ready = 1'b1;
    fetch_en  = 1'b1;
    gb = gnt_log.size();
    wb = got_addr.size();
    wait_got(wb + 8, "t1");
    fetch_en = 1'b0;
    wait_idle("t1");
    for (int i = 0; i < 3; i++)
      check_eq($sformatf("t1_gnt%0d", i), gnt_log[gb + i], 32'h8000_0000 + 32'(4 * i));
    for (int i = 0; i < 6; i++) begin
      check_eq($sformatf("t1_addr%0d", i), got_addr[wb + i], 32'h8000_0000 + 32'(4 * i));
      check_eq($sformatf("t1_data%0d", i), got_data[wb + i], mem_word(32'h8000_0000 + 32'(4 * i)));
    end

    // Consumer stalled: credit stops issue after four grants.
    out_ready = 1'b0;
    pulse_redirect(32'h8000_0000);
    gb = gnt_log.size();
    wb = got_addr.size();
    fetch_en = 1'b1;
    repeat (30) tick();
    check_eq("t2_grants", 32'(gnt_log.size() - gb), 32'd4);
    check_eq("t2_req", {31'd0, instr_req}, 32'd0);
    check_eq("t2_oval", {31'd0, out_valid}, 32'd1);
    check_eq("t2_head", out_addr, 32'h8000_0000);
    check_eq("t2_outst", {27'd0, outstanding}, 32'd0);
    out_ready = 1'b1;
    wait_got(wb + 6, "t2");
    fetch_en = 1'b0;
    wait_idle("t2");
    check_eq("t2_resume_gnt", gnt_log[gb + 4], 32'h8000_0010);
    check_eq("t2_resume_out", got_addr[wb + 4], 32'h8000_0010);

    // Redirect with two granted and one pending ungranted request.
    pulse_redirect(32'h8000_0000);
    resp_wait = 20;
    gb = gnt_log.size();
    wb = got_addr.size();
    gnt_limit = gb + 2;
    fetch_en = 1'b1;
    repeat (6) tick();
    check_eq("t3_outst", {27'd0, outstanding}, 32'd2);
    check_eq("t3_pend_req", {31'd0, instr_req}, 32'd1);
    check_eq("t3_pend_addr", instr_addr, 32'h8000_0008);
    pulse_redirect(32'h8000_0103);
    check_eq("t3_hold_req", {31'd0, instr_req}, 32'd1);
    check_eq("t3_hold_addr", instr_addr, 32'h8000_0008);
    rand_mode = 1'b1;
    gnt_limit = 32'h4000_0000;
    wait_got(wb + 4, "t3");
    fetch_en = 1'b0;
    wait_idle("t3");
    check_eq("t3_first", got_addr[wb], 32'h8000_0100);
    check_eq("t3_first_data", got_data[wb], mem_word(32'h8000_0100));
    check_eq("t3_second", got_addr[wb + 1], 32'h8000_0104);
    check_eq("t3_dropped", 32'((gnt_log.size() - gb) - (got_addr.size() - wb)), 32'd3);

    // Address wrap past the top of memory.
    rand_mode = 1'b0;
    resp_wait = 0;
    pulse_redirect(32'hFFFF_FFF8);
    gb = gnt_log.size();
    wb = got_addr.size();
    fetch_en = 1'b1;
    k = 0;
    while (gnt_log.size() < gb + 3 && k < 200) begin
      tick();
      k++;
    end
    fetch_en = 1'b0;
    check_eq("t4_gnt_bound", {31'd0, (k < 200)}, 32'd1);
    wait_idle("t4");
    check_eq("t4_gnt0", gnt_log[gb],     32'hFFFF_FFF8);
    check_eq("t4_gnt1", gnt_log[gb + 1], 32'hFFFF_FFFC);
    check_eq("t4_gnt2", gnt_log[gb + 2], 32'h0000_0000);
    check_eq("t4_out2", got_addr[wb + 2], 32'h0000_0000);

    // Responder error on a single word.
    err_addr = 32'h8000_0008;
    pulse_redirect(32'h8000_0000);
    wb = got_addr.size();
    fetch_en = 1'b1;
    wait_got(wb + 4, "t5");
    fetch_en = 1'b0;
    wait_idle("t5");
    for (int i = 0; i < 4; i++) begin
      check_eq($sformatf("t5_addr%0d", i), got_addr[wb + i], 32'h8000_0000 + 32'(4 * i));
      check_eq($sformatf("t5_err%0d", i), {31'd0, got_err[wb + i]}, {31'd0, (i == 2)});
    end
    err_addr = 32'h1;

    // Unsolicited response, then an asynchronous reset mid-traffic.
    check_eq("t6_proto_pre", {31'd0, proto_err}, 32'd0);
    force_cnt++;
    tick();
    tick();
    check_eq("t6_proto_set", {31'd0, proto_err}, 32'd1);
    check_eq("t6_no_push", {31'd0, out_valid}, 32'd0);
    repeat (5) tick();
    check_eq("t6_proto_sticky", {31'd0, proto_err}, 32'd1);

    rand_mode = 1'b1;
    pulse_redirect(32'h8000_0040);
    fetch_en = 1'b1;
    repeat (10) tick();
    #2;
    rst = 1'b1;
    #1;
    check_reset_outputs("rst_async");
    fetch_en = 1'b0;
    repeat (2) tick();
    rst = 1'b0;
    repeat (3) tick();
    check_eq("t6_post_req", {31'd0, instr_req}, 32'd0);

    check_eq("max_outstanding_ok", {31'd0, (max_out <= 4)}, 32'd1);
    check_eq("req_stable_viol", 32'(stab_viol), 32'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #900000;
    $display("FAIL global_timeout: got timeout expected finish");
    $fatal(1, "timeout");
  end

endmodule
